// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one-hot grant plus encoded index, zero-cycle combinational grant.
// Priority rotates only when the consumer accepts (update_lru); grant holds steady while it waits.

module rr_onehot_enc #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_oh,
    output logic [IDX_W-1:0] o_idx
);
    // OR of per-bit indices: exact for one-hot, 0 for an all-zero vector.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_oh[i]) o_idx = o_idx | IDX_W'(i);
        end
    end
endmodule

module rr_grant_arbiter #(
    parameter int NUM_ENTRIES = 4,
    parameter int INDEX_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_ENTRIES-1:0] request,
    input  logic                   update_lru,
    output logic [NUM_ENTRIES-1:0] grant_oh,
    output logic                   grant_valid,
    output logic [INDEX_WIDTH-1:0] grant_idx
);
    logic [NUM_ENTRIES-1:0] r_last_grant;
    logic [NUM_ENTRIES-1:0] w_mask_hi;
    logic [NUM_ENTRIES-1:0] w_req_hi;
    logic [NUM_ENTRIES-1:0] w_pick_hi;
    logic [NUM_ENTRIES-1:0] w_pick_all;

    // Entries strictly above the last grant; empty when the last grant is the top entry.
    assign w_mask_hi  = ~((r_last_grant << 1) - NUM_ENTRIES'(1));
    assign w_req_hi   = request & w_mask_hi;
    assign w_pick_hi  = w_req_hi & (~w_req_hi + NUM_ENTRIES'(1));
    assign w_pick_all = request & (~request + NUM_ENTRIES'(1));

    // No requester above the last grant: wrap to the lowest requester (may be the last grant itself).
    assign grant_oh    = (|w_req_hi) ? w_pick_hi : w_pick_all;
    assign grant_valid = |grant_oh;

    rr_onehot_enc #(
        .WIDTH (NUM_ENTRIES),
        .IDX_W (INDEX_WIDTH)
    ) u_enc (
        .i_oh  (grant_oh),
        .o_idx (grant_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= {1'b1, {(NUM_ENTRIES-1){1'b0}}};
        end else if (update_lru && grant_valid) begin
            r_last_grant <= grant_oh;
        end
    end
endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (NUM_ENTRIES=4) with hand-computed expectations.
module tb_rr_grant_arbiter;
    logic       clk;
    logic       reset;
    logic [3:0] request;
    logic       update_lru;
    logic [3:0] grant_oh;
    logic       grant_valid;
    logic [1:0] grant_idx;

    int n_tests;
    int n_fail;

    rr_grant_arbiter #(.NUM_ENTRIES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .request     (request),
        .update_lru  (update_lru),
        .grant_oh    (grant_oh),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] oh, input logic v, input logic [1:0] idx);
        chk({tag, ".oh"},    32'(grant_oh),    32'(oh));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
        chk({tag, ".idx"},   32'(grant_idx),   32'(idx));
    endtask

    initial begin
        logic [1:0] rot_seq [6];
        logic [1:0] r_exp;
        n_tests = 0;
        n_fail  = 0;
        rot_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // 1: reset priority
        reset      = 1'b0;
        request    = 4'b1111;
        update_lru = 1'b0;
        #1;
        chk_grant("rst_hold", 4'b0001, 1'b1, 2'd0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk_grant("rst_rel", 4'b0001, 1'b1, 2'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stable.oh", 32'(grant_oh), 32'h1);
        end

        // 2: rotation with continuous accept
        update_lru = 1'b1;
        for (int c = 0; c < 6; c++) begin
            r_exp = rot_seq[c];
            chk("rot.idx", 32'(grant_idx), 32'(r_exp));
            chk("rot.oh",  32'(grant_oh),  32'(4'b0001 << r_exp));
            tick();
        end

        // 3: skip idle entries (last accepted idx = 1)
        request = 4'b1001;
        #1;
        chk_grant("skip_a", 4'b1000, 1'b1, 2'd3);
        tick();
        chk_grant("skip_b", 4'b0001, 1'b1, 2'd0);
        tick();

        // 4: no request, then same-cycle grant
        request = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk_grant("none", 4'b0000, 1'b0, 2'd0);
            tick();
        end
        request = 4'b0100;
        #1;
        chk_grant("after_none", 4'b0100, 1'b1, 2'd2);
        tick();

        // 5: sole requester repeats
        request = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_grant("sole", 4'b0010, 1'b1, 2'd1);
            tick();
        end

        // 6: async reset mid-operation
        request = 4'b0100;
        #1;
        tick();
        request    = 4'b1111;
        update_lru = 1'b0;
        #1;
        chk_grant("pre_rst", 4'b1000, 1'b1, 2'd3);
        #1;
        reset = 1'b0;
        #1;
        chk_grant("async_rst", 4'b0001, 1'b1, 2'd0);
        #2;
        reset = 1'b1;
        #1;
        chk_grant("rst_released", 4'b0001, 1'b1, 2'd0);
        tick();
        chk("hold_a.oh", 32'(grant_oh), 32'h1);
        tick();
        chk("hold_b.oh", 32'(grant_oh), 32'h1);
        update_lru = 1'b1;
        tick();
        chk_grant("post_accept", 4'b0010, 1'b1, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
